// File: rtl/cp2_fetch_stage.sv
`timescale 1ns/1ps
// CP2 fetch stage: buffers CPU coprocessor words in a small FIFO and issues them one per cycle to decode.
// Build option CP2_FETCH_ILLEGAL_TRAP_EN: consume non-COP2 words without buffering and pulse illegal_instr.
module cp2_fetch_stage #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cp2_valid,
  input  logic [31:0]   cpu_cp2_instr,
  output logic          cp2_cpu_ready,
  input  logic          stall,
  input  logic          flush,
  output logic [31:0]   fetch_instruction,
  output logic          decode_en,
  output logic [AW:0]   fifo_count,
  output logic          illegal_instr,
  output logic [1:0]    fsm_state
);

  // Handshake: a word transfers on a rising edge where cpu_cp2_valid and cp2_cpu_ready are both high;
  // the CPU keeps the word stable until then, and ready depends only on registered occupancy and flush.

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_RUN     = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fetch_q, fetch_d;
  logic          dec_q, dec_d;
  logic          ill_q, ill_d;
  state_t        state_q, state_d;

  logic          opcode_ok;
  logic          offer;
  logic          push;
  logic          pop;

`ifdef CP2_FETCH_ILLEGAL_TRAP_EN
  assign opcode_ok = (cpu_cp2_instr[31:26] == 6'b010010);
`else
  assign opcode_ok = 1'b1;
`endif

  assign cp2_cpu_ready = !flush && (count_q != FULL);
  assign offer         = cpu_cp2_valid && cp2_cpu_ready;
  assign push          = offer && opcode_ok;
  assign pop           = (count_q != '0) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cpu_cp2_instr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fetch_d  = fetch_q;
    dec_d    = 1'b0;
    ill_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      fetch_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        fetch_d  = mem_q[rd_ptr_q];
        dec_d    = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A consumed-but-rejected word only exists when the opcode check is compiled in.
      ill_d = offer && !opcode_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) state_d = S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            state_d = S_STALLED;
          end else if (pop && !push && (count_q == (AW+1)'(1))) begin
            state_d = S_EMPTY;
          end
        end
        S_STALLED: begin
          if (!stall) begin
            state_d = ((count_q != '0) || push) ? S_RUN : S_EMPTY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fetch_q  <= '0;
      dec_q    <= 1'b0;
      ill_q    <= 1'b0;
      state_q  <= S_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fetch_q  <= fetch_d;
      dec_q    <= dec_d;
      ill_q    <= ill_d;
      state_q  <= state_d;
    end
  end

  assign fetch_instruction = fetch_q;
  assign decode_en         = dec_q;
  assign fifo_count        = count_q;
  assign illegal_instr     = ill_q;
  assign fsm_state         = state_q;

endmodule

// File: doc/cp2_fetch_stage.md
Name: cp2_fetch_stage

Overview:
Front stage of the CP2 coprocessor pipeline. It accepts coprocessor instructions from the main CPU over a valid/ready handshake and buffers them in a small FIFO. It issues one instruction at a time to cp2_decode_stage through a registered fetch_instruction and a one-cycle decode_en strobe, and it honours a downstream stall and a pipeline flush.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two.
AW, 2, FIFO pointer width; AW = log2(DEPTH).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous active-low reset (`RESET_ENABLE = 0, `RESET_EDGE = negedge).
cpu_cp2_valid  in  1  CPU presents an instruction.
cpu_cp2_instr  in  32  instruction word (`WORDDATABUS).
cp2_cpu_ready  out  1  combinational; high means the FIFO accepts a word this cycle.
stall  in  1  downstream hold; no issue while high.
flush  in  1  synchronous discard of all buffered and issued state.
fetch_instruction  out  32  registered; word currently presented to decode.
decode_en  out  1  registered; one-cycle strobe for each newly issued word.
fifo_count  out  AW+1  registered occupancy, range 0..DEPTH.
illegal_instr  out  1  registered one-cycle pulse for a rejected non-COP2 word (optional feature).

Behaviour:
- Reset (rst=0, async): clear FIFO pointers; fifo_count=0, fetch_instruction=0, decode_en=0, illegal_instr=0; state=EMPTY.
- Ready signal: cp2_cpu_ready = !flush && (fifo_count != DEPTH). It is derived from registered occupancy only.
  - A push on a full FIFO is refused even when a pop occurs in the same cycle.
- Push: occurs when cpu_cp2_valid && cp2_cpu_ready && opcode_ok.
  - The word is written at wr_ptr, and wr_ptr increments modulo DEPTH (wraps).
  - opcode_ok is always 1 unless the optional feature is compiled in.
- Pop/issue: occurs when fifo_count != 0, stall=0 and flush=0.
  - fetch_instruction <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; decode_en <= 1.
  - In every other cycle decode_en <= 0 and fetch_instruction holds its value, so decode never re-executes a held word.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
  - A push-only cycle increments fifo_count; a pop-only cycle decrements it.
- No bypass: a word pushed into an empty FIFO in cycle N produces decode_en in cycle N+1 at the earliest, i.e. 1-cycle latency from acceptance to strobe.
- Flush (highest priority): pointers and fifo_count go to 0, decode_en <= 0, fetch_instruction <= 0, and any same-cycle push or pop is suppressed.
- State machine, on registered state:
  - EMPTY (count=0): push -> RUN.
  - RUN (count>0, stall=0): issue each cycle; pop with no push at count=1 -> EMPTY; stall=1 -> STALLED.
  - STALLED: outputs held, pushes still accepted up to full; stall=0 -> RUN if count>0, else EMPTY.
  - Flush from any state -> EMPTY.
- Stall and flush together: flush wins.
- Reset asserted mid-operation: all buffered words are lost immediately and no decode_en is produced after release until a new push.

Optional Feature:
CP2_FETCH_ILLEGAL_TRAP_EN
- Defined:
  - opcode_ok = (cpu_cp2_instr[31:26] == 6'b010010), the COP2 major opcode.
  - A valid word offered while ready, with opcode_ok=0, is consumed: the handshake completes but the word is not written.
  - illegal_instr <= 1 for one cycle in that case.
- Not defined: opcode_ok = 1, every offered word is buffered, and illegal_instr is tied to 0.

Test Plan:
- Reset then push 0x48000001 (one cycle valid) -> fifo_count=1 next edge; decode_en=1 with fetch_instruction=0x48000001 one cycle later, then decode_en=0 and count=0.
- stall=1, push 4 words A..D -> cp2_cpu_ready=0 at count=4 while a 5th word E is held valid; release stall -> decode_en on 4 consecutive cycles carrying A,B,C,D in order; E accepted once ready rises.
- Steady stream, valid=1 every cycle with stall=0 -> count stays at 1 and decode_en=1 every cycle after the first; 10 words issued in order, exercising pointer wrap past DEPTH.
- Stall asserted while word B is presented -> fetch_instruction holds B and decode_en=0 for the whole stall, with no duplicate strobe on release.
- Count=3 plus flush and a same-cycle push -> next cycle count=0, decode_en=0, fetch_instruction=0, and the pushed word is never issued.
- With CP2_FETCH_ILLEGAL_TRAP_EN defined, push 0x8C000000 -> illegal_instr=1 for one cycle, count stays 0, no decode_en; without the macro the same word is issued normally.
